// File: rtl/sensor_window_counter.sv
// rtl/sensor_window_counter.sv - windowed rising-edge counter for an asynchronous sensor input
// Results wait in HOLD until the consumer accepts them, so no result is ever overwritten.
module sensor_window_counter #(
   parameter int CNT_WIDTH   = 32,
   parameter int WIN_WIDTH   = 32,
   parameter int SYNC_STAGES = 2,
   parameter int ID_WIDTH    = 8
) (
   input  logic                 ACLK,
   input  logic                 ARESETN,
   input  logic                 sensor_in,
   input  logic                 start,
   input  logic [WIN_WIDTH-1:0] window_len,
   input  logic                 continuous,
   output logic [CNT_WIDTH-1:0] count_out,
   output logic [ID_WIDTH-1:0]  sample_id,
   output logic                 overflow,
   output logic                 count_valid,
   input  logic                 count_ready,
   output logic                 busy
);
   typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, HOLD = 2'd2} state_t;

   state_t                 state_q, state_d;
   logic [1:0]             rst_sync_q, rst_sync_d;
   logic                   rst_n;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   edge_q, edge_d, edge_pulse;
   logic [WIN_WIDTH-1:0]   win_cnt_q, win_cnt_d, win_len_eff;
   logic [CNT_WIDTH-1:0]   acc_q, acc_d, acc_next;
   logic [CNT_WIDTH-1:0]   count_out_q, count_out_d;
   logic                   ovf_q, ovf_d, ovf_next;
   logic                   overflow_q, overflow_d;
   logic [ID_WIDTH-1:0]    sample_id_q, sample_id_d;
   logic                   win_load, last_cycle, acc_max;

   // Reset asserts immediately but releases only after two clean ACLK edges.
   always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) rst_sync_q <= '0;
      else          rst_sync_q <= rst_sync_d;
   end

   assign rst_n = rst_sync_q[1];

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], sensor_in};
      edge_d = sync_q[SYNC_STAGES-1];
   end

   assign edge_pulse  = sync_q[SYNC_STAGES-1] & ~edge_q;
   assign win_len_eff = (window_len == '0) ? WIN_WIDTH'(1) : window_len;
   assign last_cycle  = (state_q == COUNT) && (win_cnt_q == WIN_WIDTH'(1));
   assign win_load    = ((state_q == IDLE) && start) ||
                        ((state_q == HOLD) && count_ready && continuous);

   always_ff @(posedge ACLK or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = COUNT;
         COUNT:   if (last_cycle) state_d = HOLD;
         HOLD:    if (count_ready) state_d = continuous ? COUNT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy        = (state_q != IDLE);
      count_valid = (state_q == HOLD);
   end

   // The final window cycle's edge is folded into the published result.
   always_comb begin
      acc_max     = &acc_q;
      acc_next    = (edge_pulse && !acc_max) ? acc_q + CNT_WIDTH'(1) : acc_q;
      ovf_next    = ovf_q | (edge_pulse & acc_max);
      win_cnt_d   = win_cnt_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      count_out_d = count_out_q;
      overflow_d  = overflow_q;
      sample_id_d = sample_id_q;
      if (win_load) begin
         win_cnt_d = win_len_eff;
         acc_d     = '0;
         ovf_d     = 1'b0;
      end else if (state_q == COUNT) begin
         win_cnt_d = win_cnt_q - WIN_WIDTH'(1);
         acc_d     = acc_next;
         ovf_d     = ovf_next;
         if (last_cycle) begin
            count_out_d = acc_next;
            overflow_d  = ovf_next;
            sample_id_d = sample_id_q + ID_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge ACLK or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= '0;
         edge_q      <= 1'b0;
         win_cnt_q   <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         count_out_q <= '0;
         overflow_q  <= 1'b0;
         sample_id_q <= '0;
      end else begin
         sync_q      <= sync_d;
         edge_q      <= edge_d;
         win_cnt_q   <= win_cnt_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         count_out_q <= count_out_d;
         overflow_q  <= overflow_d;
         sample_id_q <= sample_id_d;
      end
   end

   assign count_out = count_out_q;
   assign overflow  = overflow_q;
   assign sample_id = sample_id_q;

endmodule

// File: tb/tb_sensor_window_counter.sv
// tb/tb_sensor_window_counter.sv - self-checking bench for sensor_window_counter
// Expected counts come from the recorded sensor history, not from the design.
module tb_sensor_window_counter;
   localparam int SS = 2;

   logic        ACLK = 1'b0, ARESETN = 1'b1, sensor_in = 1'b0;
   logic        start = 1'b0, start_s = 1'b0, continuous = 1'b0;
   logic        count_ready = 1'b0, ready_s = 1'b0;
   logic [31:0] window_len = '0;
   logic [31:0] count_out;
   logic [7:0]  sample_id, sample_id_s;
   logic        overflow, count_valid, busy;
   logic [3:0]  count_out_s;
   logic        overflow_s, count_valid_s, busy_s;

   int   checks = 0, failures = 0, sid = 0;
   int   cyc = 0, mode = 0, period = 8, ph = 0;
   logic level = 1'b0;
   bit   hist [0:16383];

   sensor_window_counter u_dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .sensor_in(sensor_in), .start(start),
      .window_len(window_len), .continuous(continuous), .count_out(count_out),
      .sample_id(sample_id), .overflow(overflow), .count_valid(count_valid),
      .count_ready(count_ready), .busy(busy)
   );

   sensor_window_counter #(.CNT_WIDTH(4)) u_sat (
      .ACLK(ACLK), .ARESETN(ARESETN), .sensor_in(sensor_in), .start(start_s),
      .window_len(window_len), .continuous(1'b0), .count_out(count_out_s),
      .sample_id(sample_id_s), .overflow(overflow_s), .count_valid(count_valid_s),
      .count_ready(ready_s), .busy(busy_s)
   );

   always #5 ACLK = ~ACLK;

   always @(posedge ACLK) begin
      cyc <= cyc + 1;
      hist[(cyc + 1) % 16384] <= sensor_in;
   end

   always @(negedge ACLK) begin
      ph <= ph + 1;
      case (mode)
         0:       sensor_in <= level;
         1:       sensor_in <= ((ph % period) < (period / 2));
         default: sensor_in <= 1'($urandom_range(0, 1));
      endcase
   end

   // Rising edges of the synchronised sensor seen over window cycles first..first+n-1.
   function automatic int exp_edges(input int first, input int n);
      int c = 0;
      for (int t = first; t < first + n; t++)
         if (hist[(t - SS + 1) % 16384] && !hist[(t - SS) % 16384]) c++;
      return c;
   endfunction

   task automatic do_start(input bit sat, input int n, output int t0);
      window_len = 32'(n);
      if (sat) start_s = 1'b1;
      else     start   = 1'b1;
      t0 = cyc;
      @(negedge ACLK);
      start   = 1'b0;
      start_s = 1'b0;
   endtask

   task automatic wait_valid(input bit sat, output int at);
      at = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge ACLK);
         if ((sat ? count_valid_s : count_valid) === 1'b1) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic handshake();
      count_ready = 1'b1;
      @(negedge ACLK);
      count_ready = 1'b0;
   endtask

   task automatic test_reset();
      mode = 2;
      repeat (2) @(negedge ACLK);
      ARESETN = 1'b0;
      repeat (20) @(negedge ACLK);
      checks++; if ({count_out, sample_id, overflow, count_valid, busy} !== '0) begin
         failures++; $display("FAIL reset_hold: outputs=%h want 0", {count_out, sample_id, overflow, count_valid, busy});
      end
      checks++; if ({count_out_s, sample_id_s, overflow_s, count_valid_s, busy_s} !== '0) begin
         failures++; $display("FAIL reset_hold_sat: outputs=%h want 0", {count_out_s, sample_id_s, overflow_s, count_valid_s, busy_s});
      end
      ARESETN = 1'b1;
      repeat (5) @(negedge ACLK);
      checks++; if ({count_out, sample_id, overflow, count_valid, busy} !== '0) begin
         failures++; $display("FAIL reset_release: outputs=%h want 0", {count_out, sample_id, overflow, count_valid, busy});
      end
   endtask

   task automatic test_basic();
      int t0, at, e;
      mode = 1; period = 8;
      repeat (24) @(negedge ACLK);
      do_start(0, 80, t0);
      wait_valid(0, at);
      sid++;
      e = exp_edges(t0 + 1, 80);
      checks++; if (at !== t0 + 81) begin failures++; $display("FAIL basic_latency: got %0d want %0d", at - t0, 81); end
      checks++; if (count_out !== 32'd10) begin failures++; $display("FAIL basic_count: got %0d want 10", count_out); end
      checks++; if (count_out !== 32'(e)) begin failures++; $display("FAIL basic_model: got %0d want %0d", count_out, e); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL basic_ovf: got %b want 0", overflow); end
      checks++; if (sample_id !== 8'(sid)) begin failures++; $display("FAIL basic_id: got %0d want %0d", sample_id, sid); end
      handshake();
      checks++; if ({count_valid, busy} !== 2'b00) begin
         failures++; $display("FAIL basic_release: valid/busy=%b want 00", {count_valid, busy});
      end
   endtask

   task automatic test_static();
      int t0, at;
      mode = 0; level = 1'b1;
      repeat (10) @(negedge ACLK);
      do_start(0, 50, t0);
      wait_valid(0, at);
      sid++;
      checks++; if (at !== t0 + 51) begin failures++; $display("FAIL static_latency: got %0d want 51", at - t0); end
      checks++; if (count_out !== 32'd0) begin failures++; $display("FAIL static_count: got %0d want 0", count_out); end
      handshake();
   endtask

   task automatic test_zero_window();
      int t0, at, e;
      mode = 2;
      count_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(3, 9)) @(negedge ACLK);
         do_start(0, 0, t0);
         wait_valid(0, at);
         sid++;
         e = exp_edges(t0 + 1, 1);
         checks++; if (at !== t0 + 2) begin failures++; $display("FAIL zero_latency: got %0d want 2", at - t0); end
         checks++; if (count_out !== 32'(e)) begin failures++; $display("FAIL zero_count: got %0d want %0d", count_out, e); end
         checks++; if (sample_id !== 8'(sid)) begin failures++; $display("FAIL zero_id: got %0d want %0d", sample_id, sid); end
         @(negedge ACLK);
         checks++; if (count_valid !== 1'b0) begin failures++; $display("FAIL zero_release: got %b want 0", count_valid); end
      end
      count_ready = 1'b0;
   endtask

   task automatic test_ignored_start();
      int t0, at, e, n;
      mode = 2;
      for (int i = 0; i < 5; i++) begin
         n = $urandom_range(6, 60);
         do_start(0, n, t0);
         repeat ($urandom_range(0, n - 5)) @(negedge ACLK);
         start = 1'b1;
         window_len = 32'($urandom_range(1, 200));
         @(negedge ACLK);
         start = 1'b0;
         wait_valid(0, at);
         sid++;
         e = exp_edges(t0 + 1, n);
         checks++; if (at !== t0 + n + 1) begin failures++; $display("FAIL ign_latency: got %0d want %0d", at - t0, n + 1); end
         checks++; if (count_out !== 32'(e)) begin failures++; $display("FAIL ign_count: got %0d want %0d", count_out, e); end
         checks++; if (sample_id !== 8'(sid)) begin failures++; $display("FAIL ign_id: got %0d want %0d", sample_id, sid); end
         handshake();
         checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_idle: busy=%b want 0", busy); end
      end
   endtask

   task automatic test_saturation();
      int t0, at, e;
      mode = 1; period = 4;
      repeat (12) @(negedge ACLK);
      do_start(1, 100, t0);
      wait_valid(1, at);
      e = exp_edges(t0 + 1, 100);
      checks++; if (at !== t0 + 101) begin failures++; $display("FAIL sat_latency: got %0d want 101", at - t0); end
      checks++; if (count_out_s !== 4'((e > 15) ? 15 : e)) begin failures++; $display("FAIL sat_count: got %0d want %0d", count_out_s, (e > 15) ? 15 : e); end
      checks++; if (overflow_s !== (e > 15)) begin failures++; $display("FAIL sat_ovf: got %b want %b", overflow_s, e > 15); end
      checks++; if ({count_out_s, overflow_s} !== 5'b11111) begin failures++; $display("FAIL sat_fixed: got %0d/%b want 15/1", count_out_s, overflow_s); end
      checks++; if (sample_id_s !== 8'd1) begin failures++; $display("FAIL sat_id: got %0d want 1", sample_id_s); end
      ready_s = 1'b1;
      @(negedge ACLK);
      ready_s = 1'b0;
      checks++; if (count_valid_s !== 1'b0) begin failures++; $display("FAIL sat_release: got %b want 0", count_valid_s); end
   endtask

   task automatic test_back_to_back();
      int t0, at, h, e;
      mode = 1; period = 8; continuous = 1'b1;
      repeat (16) @(negedge ACLK);
      do_start(0, 40, t0);
      wait_valid(0, at);
      sid++;
      checks++; if (at !== t0 + 41) begin failures++; $display("FAIL cont_latency1: got %0d want 41", at - t0); end
      checks++; if (count_out !== 32'd5) begin failures++; $display("FAIL cont_count1: got %0d want 5", count_out); end
      for (int i = 0; i < 30; i++) begin
         @(negedge ACLK);
         checks++; if ({count_valid, busy, count_out, sample_id} !== {2'b11, 32'd5, 8'(sid)}) begin
            failures++; $display("FAIL cont_hold: valid=%b busy=%b count=%0d id=%0d want 1/1/5/%0d", count_valid, busy, count_out, sample_id, sid);
         end
      end
      count_ready = 1'b1;
      h = cyc;
      @(negedge ACLK);
      count_ready = 1'b0;
      window_len = 32'd7;
      checks++; if ({count_valid, busy} !== 2'b01) begin failures++; $display("FAIL cont_rearm: valid/busy=%b want 01", {count_valid, busy}); end
      wait_valid(0, at);
      sid++;
      e = exp_edges(h + 1, 40);
      checks++; if (at !== h + 41) begin failures++; $display("FAIL cont_latency2: got %0d want 41", at - h); end
      checks++; if (count_out !== 32'(e) || e != 5) begin failures++; $display("FAIL cont_count2: got %0d model %0d want 5", count_out, e); end
      checks++; if (sample_id !== 8'(sid)) begin failures++; $display("FAIL cont_id: got %0d want %0d", sample_id, sid); end
      continuous = 1'b0;
      handshake();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cont_stop: busy=%b want 0", busy); end
   endtask

   task automatic test_midreset();
      int t0, at, e;
      mode = 2;
      do_start(0, 80, t0);
      repeat (19) @(negedge ACLK);
      ARESETN = 1'b0;
      #1;
      checks++; if ({count_valid, busy} !== 2'b00) begin failures++; $display("FAIL mid_async: valid/busy=%b want 00", {count_valid, busy}); end
      @(negedge ACLK);
      checks++; if ({count_out, sample_id, overflow} !== '0) begin
         failures++; $display("FAIL mid_clear: count=%0d id=%0d ovf=%b want 0", count_out, sample_id, overflow);
      end
      repeat (3) @(negedge ACLK);
      ARESETN = 1'b1;
      sid = 0;
      repeat (6) @(negedge ACLK);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_idle: busy=%b want 0", busy); end
      do_start(0, 10, t0);
      wait_valid(0, at);
      sid++;
      e = exp_edges(t0 + 1, 10);
      checks++; if (at !== t0 + 11) begin failures++; $display("FAIL mid_latency: got %0d want 11", at - t0); end
      checks++; if (count_out !== 32'(e)) begin failures++; $display("FAIL mid_count: got %0d want %0d", count_out, e); end
      checks++; if (sample_id !== 8'd1) begin failures++; $display("FAIL mid_id: got %0d want 1", sample_id); end
      handshake();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_static();
      test_zero_window();
      test_ignored_start();
      test_saturation();
      test_back_to_back();
      test_midreset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
